// File: rtl/branch_pred_log.sv
// branch_pred_log: in-order log of fetch-time branch predictions,
// matched against resolve outcomes to train the predictor.
// Ports: clk, rst_n (async, active-low); push, push_pred, push_pc
// log a predicted branch; resolve, resolve_taken retire the oldest.
// Outputs: decr_count_brnch / mispredict pulses, brnc_pred_log,
// mispred_pc (recovery PC), count, full, empty.
// Optional: define BPLOG_ERR_EN to add the sticky err output.
module branch_pred_log #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_pred,
  input  logic [15:0]      push_pc,
  input  logic             resolve,
  input  logic             resolve_taken,
  output logic             decr_count_brnch,
  output logic             mispredict,
  output logic             brnc_pred_log,
  output logic [15:0]      mispred_pc,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
`ifdef BPLOG_ERR_EN
  ,
  output logic             err
`endif
);

  logic             pred_q [DEPTH];
  logic [15:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;

  logic             do_res;
  logic             hit;
  logic             miss;
  logic             do_push;
  logic             head_pred;
  logic [15:0]      head_pc;

  assign count = cnt;
  assign full  = (cnt == (PTR_W+1)'(DEPTH));
  assign empty = (cnt == '0);

  assign head_pred = pred_q[head];
  assign head_pc   = pc_q[head];

  assign do_res = resolve && !empty;
  assign hit    = do_res && (head_pred == resolve_taken);
  assign miss   = do_res && !hit;
  // A matching pop frees the slot the push needs, so a full
  // log still accepts it; a flush discards wrong-path pushes.
  assign do_push = push && !miss && (!full || hit);

  always_ff @(posedge clk) begin
    if (do_push) begin
      pred_q[tail] <= push_pred;
      pc_q[tail]   <= push_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (miss) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (hit)
        head <= head + PTR_W'(1);
      if (do_push)
        tail <= tail + PTR_W'(1);
      cnt <= cnt + (PTR_W+1)'(do_push)
                 - (PTR_W+1)'(hit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decr_count_brnch <= 1'b0;
      mispredict       <= 1'b0;
      brnc_pred_log    <= 1'b0;
      mispred_pc       <= 16'h0000;
    end else begin
      decr_count_brnch <= hit;
      mispredict       <= miss;
      if (do_res)
        brnc_pred_log <= head_pred;
      if (miss)
        mispred_pc <= head_pc;
    end
  end

`ifdef BPLOG_ERR_EN
  logic bad_push;
  logic bad_res;

  assign bad_push = push && full && !do_res;
  assign bad_res  = resolve && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (bad_push || bad_res)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_branch_pred_log.sv
// tb_branch_pred_log: directed bench with a queue-based model
// compared every cycle, plus literal checks of key results.
module tb_branch_pred_log;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           push = 1'b0;
  logic           push_pred = 1'b0;
  logic [15:0]    push_pc = 16'h0;
  logic           resolve = 1'b0;
  logic           resolve_taken = 1'b0;
  logic           decr_count_brnch;
  logic           mispredict;
  logic           brnc_pred_log;
  logic [15:0]    mispred_pc;
  logic [PTR_W:0] count;
  logic           full;
  logic           empty;
`ifdef BPLOG_ERR_EN
  logic           err;
`endif

  branch_pred_log #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_pred(push_pred),
    .push_pc(push_pc),
    .resolve(resolve),
    .resolve_taken(resolve_taken),
    .decr_count_brnch(decr_count_brnch),
    .mispredict(mispredict),
    .brnc_pred_log(brnc_pred_log),
    .mispred_pc(mispred_pc),
    .count(count),
    .full(full),
    .empty(empty)
`ifdef BPLOG_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h",
               name, act, exp);
    end
  endtask

  // Model: queue of {pred, pc} in arrival order.
  logic [16:0] mq[$];
  logic        m_decr = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_log = 1'b0;
  logic [15:0] m_pc = 16'h0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_decr = 1'b0;
      m_mis = 1'b0;
      m_log = 1'b0;
      m_pc = 16'h0;
      m_err = 1'b0;
    end else begin
      logic [16:0] e;
      logic flushed;
      flushed = 1'b0;
      m_decr = 1'b0;
      m_mis = 1'b0;
      if (resolve && mq.size() == 0)
        m_err = 1'b1;
      if (push && !resolve && mq.size() == DEPTH)
        m_err = 1'b1;
      if (resolve && mq.size() > 0) begin
        e = mq[0];
        m_log = e[16];
        if (e[16] == resolve_taken) begin
          void'(mq.pop_front());
          m_decr = 1'b1;
        end else begin
          mq.delete();
          m_mis = 1'b1;
          m_pc = e[15:0];
          flushed = 1'b1;
        end
      end
      if (push && !flushed && mq.size() < DEPTH)
        mq.push_back({push_pred, push_pc});
    end
  end

  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("count", int'(count), mq.size());
      chk("full", int'(full),
          int'(mq.size() == DEPTH));
      chk("empty", int'(empty),
          int'(mq.size() == 0));
      chk("decr", int'(decr_count_brnch),
          int'(m_decr));
      chk("mispredict", int'(mispredict),
          int'(m_mis));
      if (m_decr || m_mis)
        chk("pred_log", int'(brnc_pred_log),
            int'(m_log));
      chk("mispred_pc", int'(mispred_pc),
          int'(m_pc));
`ifdef BPLOG_ERR_EN
      chk("err", int'(err), int'(m_err));
`endif
    end
  end

  task automatic step(input logic p,
                      input logic pp,
                      input logic [15:0] pc,
                      input logic r,
                      input logic rt);
    push = p;
    push_pred = pp;
    push_pc = pc;
    resolve = r;
    resolve_taken = rt;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_decr", int'(decr_count_brnch), 0);
    chk("rst_mis", int'(mispredict), 0);
    chk("rst_log", int'(brnc_pred_log), 0);
    chk("rst_pc", int'(mispred_pc), 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    idle();

    // Single predict-taken branch retires cleanly.
    step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
    chk("t1_count1", int'(count), 1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t1_count0", int'(count), 0);
    chk("t1_decr", int'(decr_count_brnch), 1);
    chk("t1_log", int'(brnc_pred_log), 1);
    idle();
    chk("t1_decr_off", int'(decr_count_brnch), 0);

    // Mismatch on the oldest of three flushes all.
    step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0020, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0030, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("t2_mis", int'(mispredict), 1);
    chk("t2_log", int'(brnc_pred_log), 1);
    chk("t2_pc", int'(mispred_pc), 16'h0010);
    chk("t2_count", int'(count), 0);
    idle();

    // Fill, push+pop while full, then an illegal push.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'((i + 1) % 2), 16'h0100 + 16'(i),
           1'b0, 1'b0);
    chk("t3_full", int'(full), 1);
    step(1'b1, 1'b1, 16'h0104, 1'b1, 1'b1);
    chk("t3_count_keep", int'(count), 4);
    chk("t3_decr", int'(decr_count_brnch), 1);
    step(1'b1, 1'b0, 16'h0105, 1'b0, 1'b0);
    chk("t3_drop", int'(count), 4);
`ifdef BPLOG_ERR_EN
    chk("t3_err", int'(err), 1);
`endif
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("t3_count1", int'(count), 1);
    // Entry at the wrapped tail is 0x0104, pred 1.
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("t3_wrap_pc", int'(mispred_pc), 16'h0104);
    chk("t3_wrap_mis", int'(mispredict), 1);
    idle();

    // Push in the same cycle as a flush is discarded.
    step(1'b1, 1'b1, 16'h0200, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0210, 1'b1, 1'b0);
    chk("t4_count", int'(count), 0);
    chk("t4_pc", int'(mispred_pc), 16'h0200);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t4_nodecr", int'(decr_count_brnch), 0);
    chk("t4_nomis", int'(mispredict), 0);
    idle();

    // Ten overlapped push/resolve cycles, pointers wrap.
    step(1'b1, 1'b0, 16'h0300, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'(i % 2), 16'h0300 + 16'(i),
           1'b1, 1'((i - 1) % 2));
      chk("t5_log", int'(brnc_pred_log), (i - 1) % 2);
      chk("t5_decr", int'(decr_count_brnch), 1);
      chk("t5_count", int'(count), 1);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("t5_drain", int'(count), 0);
    idle();

    // Reset during a mispredict pulse clears everything.
    step(1'b1, 1'b0, 16'h0400, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("t6_mis", int'(mispredict), 1);
    chk("t6_pc", int'(mispred_pc), 16'h0400);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mis", int'(mispredict), 0);
    chk("t6_rst_pc", int'(mispred_pc), 0);
    chk("t6_rst_log", int'(brnc_pred_log), 0);
    chk("t6_rst_decr", int'(decr_count_brnch), 0);
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_full", int'(full), 0);
`ifdef BPLOG_ERR_EN
    chk("t6_rst_err", int'(err), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
